cpu_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 19-bit CPU datapath. It drives every load, select and memory strobe consumed by the instruction register, program counter, register file (A/B/C), ALU and the two external memories. It walks each instruction through fetch, decode, operand read, execute and write-back. It uses a req/ack handshake toward memory, with a wait-timeout watchdog, so memories with variable latency are tolerated.

---
 rtl/cpu_seq_pkg.sv | 41 ++++
 rtl/mem_wait_timer.sv | 39 +++
 rtl/cpu_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_seq_pkg
// Description : Shared types for the CPU instruction sequencer: state
//               encoding, opcode map and opcode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_seq_pkg;

  // Encodings are visible on the STATE debug port, so values are fixed.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_READ_OP = 3'd3,
    S_EXEC    = 3'd4,
    S_WRITE   = 3'd5,
    S_HALT    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  localparam logic [3:0] c_OP_NOP   = 4'h0;
  localparam logic [3:0] c_OP_LOAD  = 4'h8;
  localparam logic [3:0] c_OP_STORE = 4'h9;
  localparam logic [3:0] c_OP_LDI   = 4'hA;
  localparam logic [3:0] c_OP_JMP   = 4'hB;
  localparam logic [3:0] c_OP_JZ    = 4'hC;
  localparam logic [3:0] c_OP_HALT  = 4'hF;

  // ALU opcodes occupy 0x1..0x7; bit 2 then selects logic vs arithmetic.
  function automatic logic op_is_alu(input logic [3:0] op);
    return (op[3] == 1'b0) && (op != c_OP_NOP);
  endfunction

  // States that hold a memory request open until MEM_ACK.
  function automatic logic state_is_mem(input state_t s);
    return (s == S_FETCH) || (s == S_READ_OP) || (s == S_WRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Memory wait watchdog. Counts request cycles that end without
//               an acknowledge and flags the cycle in which the budget of
//               TIMEOUT unacknowledged cycles is used up.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
  parameter int TIMEOUT = 8   // legal range 2..15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,    // a memory state is being entered at this edge
  input  logic active,   // a request is outstanding this cycle
  input  logic ack,      // memory acknowledge this cycle
  output logic expired   // this is the last allowed cycle and it has no ack
);

  localparam logic [3:0] c_LAST = 4'(TIMEOUT - 1);

  logic [3:0] r_count;

  // Count completed request cycles without an ack; restart on each new access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (start) begin
      r_count <= '0;
    end else if (active && !ack) begin
      r_count <= r_count + 4'd1;
    end
  end

  // An ack in the last allowed cycle still wins over expiry.
  assign expired = active && !ack && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle instruction sequencer for the 19-bit CPU. Walks
//               each instruction through fetch, decode, operand read, execute
//               and write-back using a req/ack memory handshake guarded by a
//               wait watchdog. Strobes are decoded from the registered state;
//               status outputs and the retired-instruction count are
//               registered.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
  parameter int ADDR_WIDTH = 12,   // informational, no address path inside
  parameter int TIMEOUT    = 8,    // legal range 2..15
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN,
  input  logic [3:0]           OPCODE,
  input  logic                 ZA,
  input  logic                 MEM_ACK,
  output logic                 MEM_REQ,
  output logic                 WR_EN_DM,
  output logic                 LOAD_IR,
  output logic                 LOAD_PC,
  output logic                 INC_PC,
  output logic                 LOAD_A,
  output logic                 LOAD_B,
  output logic                 LOAD_C,
  output logic                 MODE,
  output logic                 SEL_A,
  output logic                 SEL_B,
  output logic                 BUSY,
  output logic                 HALTED,
  output logic                 ERR,
  output logic [2:0]           STATE,
  output logic [CNT_WIDTH-1:0] INSTR_COUNT
);

  import cpu_seq_pkg::*;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_busy;
  logic                   r_halted;
  logic                   r_err;
  logic [CNT_WIDTH-1:0]   r_instr_count;

  logic w_retire;
  logic w_halt_retire;
  logic w_count_inc;
  logic w_timer_start;
  logic w_expired;

  logic w_mem_req;
  logic w_wr_en_dm;
  logic w_load_ir;
  logic w_load_pc;
  logic w_inc_pc;
  logic w_load_a;
  logic w_load_b;
  logic w_load_c;
  logic w_mode;
  logic w_sel_a;
  logic w_sel_b;

  // Address width only documents the surrounding datapath.
  logic w_unused_addr_width;
  assign w_unused_addr_width = (ADDR_WIDTH > 0);

  // Next-state selection; a retiring instruction samples EN to pick FETCH or IDLE.
  always_comb begin
    w_next_state  = r_state;
    w_retire      = 1'b0;
    w_halt_retire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (EN) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (MEM_ACK)        w_next_state = S_DECODE;
        else if (w_expired) w_next_state = S_ERROR;
      end
      S_DECODE: begin
        if (op_is_alu(OPCODE)) begin
          w_next_state = S_EXEC;
        end else begin
          case (OPCODE)
            c_OP_NOP:                      w_retire     = 1'b1;
            c_OP_LDI, c_OP_JMP, c_OP_JZ:   w_next_state = S_EXEC;
            c_OP_LOAD:                     w_next_state = S_READ_OP;
            c_OP_STORE:                    w_next_state = S_WRITE;
            c_OP_HALT: begin
              w_next_state  = S_HALT;
              w_halt_retire = 1'b1;
            end
            default:                       w_next_state = S_ERROR;
          endcase
        end
      end
      S_READ_OP, S_WRITE: begin
        if (MEM_ACK)        w_retire     = 1'b1;
        else if (w_expired) w_next_state = S_ERROR;
      end
      S_EXEC: begin
        w_retire = 1'b1;
      end
      default: begin
        w_next_state = r_state;   // HALT and ERROR only leave through reset
      end
    endcase
    if (w_retire) w_next_state = EN ? S_FETCH : S_IDLE;
  end

  assign w_count_inc   = w_retire || w_halt_retire;
  assign w_timer_start = state_is_mem(w_next_state) && (w_next_state != r_state);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (CLK),
    .rst_n   (RST_N),
    .start   (w_timer_start),
    .active  (w_mem_req),
    .ack     (MEM_ACK),
    .expired (w_expired)
  );

  // Combinational strobe decode from the registered state and live inputs.
  always_comb begin
    w_mem_req  = 1'b0;
    w_wr_en_dm = 1'b0;
    w_load_ir  = 1'b0;
    w_load_pc  = 1'b0;
    w_inc_pc   = 1'b0;
    w_load_a   = 1'b0;
    w_load_b   = 1'b0;
    w_load_c   = 1'b0;
    w_mode     = 1'b0;
    w_sel_a    = 1'b0;
    w_sel_b    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (MEM_ACK) begin
          w_load_ir = 1'b1;
          w_inc_pc  = 1'b1;
        end
      end
      S_READ_OP: begin
        w_mem_req = 1'b1;
        w_sel_b   = 1'b1;
        if (MEM_ACK) begin
          w_load_a = 1'b1;
          w_load_b = 1'b1;
        end
      end
      S_EXEC: begin
        if (op_is_alu(OPCODE)) begin
          w_load_c = 1'b1;
          w_mode   = OPCODE[2];
        end else begin
          case (OPCODE)
            c_OP_LDI: begin
              w_load_c = 1'b1;
              w_sel_a  = 1'b1;
            end
            c_OP_JMP: begin
              w_load_pc = 1'b1;
              w_sel_b   = 1'b1;
            end
            c_OP_JZ: begin
              w_load_pc = ZA;
              w_sel_b   = 1'b1;
            end
            default: begin
              w_load_c = 1'b0;
            end
          endcase
        end
      end
      S_WRITE: begin
        w_mem_req  = 1'b1;
        w_wr_en_dm = 1'b1;
        w_sel_b    = 1'b1;
      end
      default: begin
        w_mem_req = 1'b0;
      end
    endcase
  end

  // State register with status flags and retire counter registered alongside.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
      r_err         <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state  <= w_next_state;
      r_busy   <= (w_next_state != S_IDLE) && (w_next_state != S_HALT) &&
                  (w_next_state != S_ERROR);
      r_halted <= (w_next_state == S_HALT);
      r_err    <= (w_next_state == S_ERROR);
      if (w_count_inc) r_instr_count <= r_instr_count + CNT_WIDTH'(1);
    end
  end

  assign MEM_REQ     = w_mem_req;
  assign WR_EN_DM    = w_wr_en_dm;
  assign LOAD_IR     = w_load_ir;
  assign LOAD_PC     = w_load_pc;
  assign INC_PC      = w_inc_pc;
  assign LOAD_A      = w_load_a;
  assign LOAD_B      = w_load_b;
  assign LOAD_C      = w_load_c;
  assign MODE        = w_mode;
  assign SEL_A       = w_sel_a;
  assign SEL_B       = w_sel_b;
  assign BUSY        = r_busy;
  assign HALTED      = r_halted;
  assign ERR         = r_err;
  assign STATE       = r_state;
  assign INSTR_COUNT = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Directed self-checking bench for cpu_sequencer. An
//               instruction-level model expands each instruction into its
//               expected per-cycle outputs; every cycle is compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

  localparam int TIMEOUT   = 8;
  localparam int CNT_WIDTH = 16;

  // Strobe bit positions in the packed comparison vector.
  localparam logic [10:0] B_REQ  = 11'h400;
  localparam logic [10:0] B_WR   = 11'h200;
  localparam logic [10:0] B_IR   = 11'h100;
  localparam logic [10:0] B_INC  = 11'h080;
  localparam logic [10:0] B_PC   = 11'h040;
  localparam logic [10:0] B_A    = 11'h020;
  localparam logic [10:0] B_B    = 11'h010;
  localparam logic [10:0] B_C    = 11'h008;
  localparam logic [10:0] B_MODE = 11'h004;
  localparam logic [10:0] B_SELA = 11'h002;
  localparam logic [10:0] B_SELB = 11'h001;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b0;
  logic za      = 1'b0;
  logic mem_ack = 1'b0;
  logic [3:0] opcode = 4'h0;

  logic mem_req, wr_en_dm, load_ir, load_pc, inc_pc;
  logic load_a, load_b, load_c, mode, sel_a, sel_b;
  logic busy, halted, err;
  logic [2:0] state;
  logic [CNT_WIDTH-1:0] instr_count;
  logic [10:0] act_strb;
  logic [39:0] act_vec;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] m_cnt = 16'd0;

  cpu_sequencer #(
    .ADDR_WIDTH (12),
    .TIMEOUT    (TIMEOUT),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .EN          (en),
    .OPCODE      (opcode),
    .ZA          (za),
    .MEM_ACK     (mem_ack),
    .MEM_REQ     (mem_req),
    .WR_EN_DM    (wr_en_dm),
    .LOAD_IR     (load_ir),
    .LOAD_PC     (load_pc),
    .INC_PC      (inc_pc),
    .LOAD_A      (load_a),
    .LOAD_B      (load_b),
    .LOAD_C      (load_c),
    .MODE        (mode),
    .SEL_A       (sel_a),
    .SEL_B       (sel_b),
    .BUSY        (busy),
    .HALTED      (halted),
    .ERR         (err),
    .STATE       (state),
    .INSTR_COUNT (instr_count)
  );

  always #5 clk = ~clk;

  assign act_strb = {mem_req, wr_en_dm, load_ir, inc_pc, load_pc, load_a,
                     load_b, load_c, mode, sel_a, sel_b};
  assign act_vec  = {7'd0, act_strb, state, busy, halted, err, instr_count};

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare at the falling edge against the
  // expected state/strobes; status flags follow from the state by definition.
  task automatic cyc(input logic e, input logic [3:0] op, input logic z,
                     input logic a, input logic [2:0] st, input logic [10:0] strb);
    logic [39:0] exp_v;
    logic ex_busy;
    en = e; opcode = op; za = z; mem_ack = a;
    @(negedge clk);
    ex_busy = (st != 3'd0) && (st != 3'd6) && (st != 3'd7);
    exp_v = {7'd0, strb, st, ex_busy, (st == 3'd6), (st == 3'd7), m_cnt};
    check($sformatf("cycle st=%0d op=%h t=%0t", st, op, $time), act_vec, exp_v);
    @(posedge clk);
    #1;
  endtask

  // Expand one instruction, starting in FETCH, into its cycle sequence.
  // fw/ow are wait cycles before the fetch / operand ack; ow >= TIMEOUT
  // means the operand ack never comes.
  task automatic instr(input logic [3:0] op, input int fw, input int ow,
                       input logic z, input logic e);
    logic [2:0]  mst;
    logic [10:0] mstrb;
    logic [10:0] mdone;
    logic [10:0] xs;
    for (int i = 0; i < fw; i++) cyc(e, op, z, 1'b0, 3'd1, B_REQ);
    cyc(e, op, z, 1'b1, 3'd1, B_REQ | B_IR | B_INC);
    cyc(e, op, z, 1'b1, 3'd2, 11'd0);
    if (op == 4'h0 || op == 4'hF) begin
      m_cnt = m_cnt + 16'd1;
    end else if (op == 4'hD || op == 4'hE) begin
      m_cnt = m_cnt;
    end else if (op == 4'h8 || op == 4'h9) begin
      mst   = (op == 4'h8) ? 3'd3 : 3'd5;
      mstrb = (op == 4'h8) ? (B_REQ | B_SELB) : (B_REQ | B_WR | B_SELB);
      mdone = (op == 4'h8) ? (B_A | B_B) : 11'd0;
      if (ow >= TIMEOUT) begin
        for (int i = 0; i < TIMEOUT; i++) cyc(e, op, z, 1'b0, mst, mstrb);
      end else begin
        for (int i = 0; i < ow; i++) cyc(e, op, z, 1'b0, mst, mstrb);
        cyc(e, op, z, 1'b1, mst, mstrb | mdone);
        m_cnt = m_cnt + 16'd1;
      end
    end else begin
      if (op >= 4'h1 && op <= 4'h3)      xs = B_C;
      else if (op >= 4'h4 && op <= 4'h7) xs = B_C | B_MODE;
      else if (op == 4'hA)               xs = B_C | B_SELA;
      else if (op == 4'hB)               xs = B_PC | B_SELB;
      else                               xs = (z ? B_PC : 11'd0) | B_SELB;
      cyc(e, op, z, 1'b1, 3'd4, xs);
      m_cnt = m_cnt + 16'd1;
    end
  endtask

  // Cycles spent in a terminal state while inputs keep toggling.
  task automatic term(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, opcode, 1'b1, i[0], st, 11'd0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b0; mem_ack = 1'b0; za = 1'b0; opcode = 4'h0;
    @(posedge clk);
    #1;
    check("reset outputs", act_vec, 40'd0);
    m_cnt = 16'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Main instruction mix.
    do_reset();
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 11'd0);
    instr(4'h5, 0, 0, 1'b0, 1'b1);
    check("count after logic op", {24'd0, instr_count}, 40'd1);
    instr(4'h8, 0, 3, 1'b0, 1'b1);
    check("count after load", {24'd0, instr_count}, 40'd2);
    instr(4'h1, 1, 0, 1'b0, 1'b1);
    instr(4'h6, 0, 0, 1'b0, 1'b1);
    instr(4'h0, 0, 0, 1'b0, 1'b1);
    instr(4'hA, 2, 0, 1'b0, 1'b1);
    instr(4'hB, 0, 0, 1'b0, 1'b1);
    instr(4'hC, 0, 0, 1'b0, 1'b1);
    instr(4'hC, 0, 0, 1'b1, 1'b1);
    instr(4'h9, 0, 2, 1'b0, 1'b1);
    instr(4'h8, 0, TIMEOUT - 1, 1'b0, 1'b0);   // ack in the last allowed cycle
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 3'd0, 11'd0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 11'd0);
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 11'd0);
    instr(4'h3, 2, 0, 1'b0, 1'b0);             // EN low while fetch waits
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 11'd0);
    check("count after mix", {24'd0, instr_count}, 40'd12);
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 11'd0);
    instr(4'hF, 0, 0, 1'b0, 1'b1);
    term(3'd6, 3);
    check("halt flags", {37'd0, halted, busy, mem_req}, 40'd4);

    // Illegal opcode after one retired NOP.
    do_reset();
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 11'd0);
    instr(4'h0, 0, 0, 1'b0, 1'b1);
    instr(4'hD, 0, 0, 1'b0, 1'b1);
    term(3'd7, 2);
    check("illegal keeps count", {23'd0, err, instr_count}, {23'd0, 1'b1, 16'd1});

    // Write never acknowledged: watchdog expiry, sticky error.
    do_reset();
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 11'd0);
    instr(4'h9, 0, TIMEOUT, 1'b0, 1'b1);
    term(3'd7, 3);
    check("timeout err sticky", {38'd0, err, wr_en_dm}, 40'd2);

    // Reset in the middle of a fetch wait drops the request without a clock.
    do_reset();
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 11'd0);
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 3'd1, B_REQ);
    check("req before async reset", {39'd0, mem_req}, 40'd1);
    rst_n = 1'b0;
    #1;
    check("req after async reset", {36'd0, mem_req, state}, 40'd0);
    m_cnt = 16'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 11'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
